// File: rtl/alu_op_decoder.sv
// Registered RV32I ALU-op decode stage (OP, OP-IMM, LUI, AUIPC) with a 2-entry skid buffer.
// Optional: define ALU_OP_DECODER_COUNT_EN to add the decode_count port and counter.
module alu_op_decoder #(
  parameter int unsigned N = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic [N-1:0]  pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    alu_control,
  output logic [1:0]    slt_mode,
  output logic [1:0]    src_a_sel,
  output logic          src_b_sel,
  output logic [N-1:0]  imm,
  output logic [4:0]    rs1,
  output logic [4:0]    rs2,
  output logic [4:0]    rd,
  output logic [N-1:0]  pc_out,
  output logic          reg_write,
  output logic          illegal
`ifdef ALU_OP_DECODER_COUNT_EN
  ,
  output logic [15:0]   decode_count
`endif
);

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_AND  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_ADD  = 4'd8,
    ALU_SUB  = 4'd12
  } alu_control_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    alu_control_t alu_control;
    logic [1:0]   slt_mode;
    logic [1:0]   src_a_sel;
    logic         src_b_sel;
    logic [N-1:0] imm;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic [N-1:0] pc_out;
    logic         reg_write;
    logic         illegal;
  } dec_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  state_t       state, state_nxt;
  dec_t         dec, out_q, skid_q;
  logic         legal;
  logic         f7_zero, f7_alt;
  logic [31:0]  u32;
  logic [N-1:0] imm_i, imm_u, imm_sh;
  logic         accept, drain;
  logic         load_out_dec, load_out_skid, load_skid;

  assign f7_zero = (instr[31:25] == 7'h00);
  assign f7_alt  = (instr[31:25] == 7'h20);
  assign u32     = {instr[31:12], 12'b0};
  assign imm_i   = N'($signed(instr[31:20]));
  assign imm_u   = N'($signed(u32));
  assign imm_sh  = N'(instr[24:20]);

  always_comb begin
    dec        = '0;
    legal      = 1'b1;
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.rd     = instr[11:7];
    dec.pc_out = pc;
    case (instr[6:0])
      OPC_OP: begin
        dec.reg_write = 1'b1;
        legal         = f7_zero;
        case (instr[14:12])
          3'b000: begin
            dec.alu_control = f7_alt ? ALU_SUB : ALU_ADD;
            legal           = f7_zero | f7_alt;
          end
          3'b001: dec.alu_control = ALU_SLL;
          3'b010: begin dec.alu_control = ALU_SUB; dec.slt_mode = 2'd1; end
          3'b011: begin dec.alu_control = ALU_SUB; dec.slt_mode = 2'd2; end
          3'b100: dec.alu_control = ALU_XOR;
          3'b101: begin
            dec.alu_control = f7_alt ? ALU_SRA : ALU_SRL;
            legal           = f7_zero | f7_alt;
          end
          3'b110: dec.alu_control = ALU_OR;
          default: dec.alu_control = ALU_AND;
        endcase
      end
      OPC_OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.src_b_sel = 1'b1;
        dec.imm       = imm_i;
        case (instr[14:12])
          3'b000: dec.alu_control = ALU_ADD;
          3'b001: begin
            dec.alu_control = ALU_SLL;
            dec.imm         = imm_sh;
            legal           = f7_zero;
          end
          3'b010: begin dec.alu_control = ALU_SUB; dec.slt_mode = 2'd1; end
          3'b011: begin dec.alu_control = ALU_SUB; dec.slt_mode = 2'd2; end
          3'b100: dec.alu_control = ALU_XOR;
          3'b101: begin
            dec.alu_control = f7_alt ? ALU_SRA : ALU_SRL;
            dec.imm         = imm_sh;
            legal           = f7_zero | f7_alt;
          end
          3'b110: dec.alu_control = ALU_OR;
          default: dec.alu_control = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        dec.alu_control = ALU_ADD;
        dec.src_a_sel   = 2'd2;
        dec.src_b_sel   = 1'b1;
        dec.imm         = imm_u;
        dec.reg_write   = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_control = ALU_ADD;
        dec.src_a_sel   = 2'd1;
        dec.src_b_sel   = 1'b1;
        dec.imm         = imm_u;
        dec.reg_write   = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Register indices and pc survive an illegal decode; everything else is cleared.
    if (!legal) begin
      dec.alu_control = ALU_NONE;
      dec.slt_mode    = 2'd0;
      dec.src_a_sel   = 2'd0;
      dec.src_b_sel   = 1'b0;
      dec.imm         = '0;
      dec.reg_write   = 1'b0;
      dec.illegal     = 1'b1;
    end
  end

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_nxt     = state;
    load_out_dec  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_nxt    = ONE;
        load_out_dec = 1'b1;
      end
      ONE: begin
        if (accept && drain) begin
          load_out_dec = 1'b1;
        end else if (accept) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      default: if (drain) begin
        state_nxt     = ONE;
        load_out_skid = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_out_dec)       out_q <= dec;
      else if (load_out_skid) out_q <= skid_q;
      if (load_skid)          skid_q <= dec;
    end
  end

`ifdef ALU_OP_DECODER_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     decode_count <= '0;
    else if (drain && !out_q.illegal) decode_count <= decode_count + 16'd1;
  end
`endif

  assign alu_control = out_q.alu_control;
  assign slt_mode    = out_q.slt_mode;
  assign src_a_sel   = out_q.src_a_sel;
  assign src_b_sel   = out_q.src_b_sel;
  assign imm         = out_q.imm;
  assign rs1         = out_q.rs1;
  assign rs2         = out_q.rs2;
  assign rd          = out_q.rd;
  assign pc_out      = out_q.pc_out;
  assign reg_write   = out_q.reg_write;
  assign illegal     = out_q.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed testbench for alu_op_decoder; checks decode fields, skid-buffer flow control and reset.
module tb_alu_op_decoder;

  localparam int unsigned N = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   instr;
  logic [N-1:0]  pc;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    alu_control;
  logic [1:0]    slt_mode;
  logic [1:0]    src_a_sel;
  logic          src_b_sel;
  logic [N-1:0]  imm;
  logic [4:0]    rs1, rs2, rd;
  logic [N-1:0]  pc_out;
  logic          reg_write;
  logic          illegal;
`ifdef ALU_OP_DECODER_COUNT_EN
  logic [15:0]   decode_count;
`endif

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  alu_op_decoder #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_control(alu_control), .slt_mode(slt_mode),
    .src_a_sel(src_a_sel), .src_b_sel(src_b_sel), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .pc_out(pc_out),
    .reg_write(reg_write), .illegal(illegal)
`ifdef ALU_OP_DECODER_COUNT_EN
    , .decode_count(decode_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0; pc = '0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_alu", 64'(alu_control), 64'd0);
    chk("rst_imm", 64'(imm), 64'd0);
    chk("rst_pc_out", 64'(pc_out), 64'd0);
    tick; tick;
    rst_n = 1'b1;

    // add x3,x1,x2
    in_valid = 1'b1; out_ready = 1'b1; instr = 32'h002081B3; pc = 32'h0;
    tick;
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_alu", 64'(alu_control), 64'd8);
    chk("add_rs1", 64'(rs1), 64'd1);
    chk("add_rs2", 64'(rs2), 64'd2);
    chk("add_rd", 64'(rd), 64'd3);
    chk("add_srcb", 64'(src_b_sel), 64'd0);
    chk("add_regw", 64'(reg_write), 64'd1);
    chk("add_illegal", 64'(illegal), 64'd0);

    // sub x5,x6,x7 then srai x1,x2,3 back-to-back
    instr = 32'h407302B3; pc = 32'h4;
    tick;
    chk("sub_alu", 64'(alu_control), 64'd12);
    chk("sub_rd", 64'(rd), 64'd5);
    chk("sub_rs1", 64'(rs1), 64'd6);
    chk("sub_rs2", 64'(rs2), 64'd7);
    chk("sub_pc", 64'(pc_out), 64'h4);
    instr = 32'h40315093; pc = 32'h8;
    tick;
    chk("srai_alu", 64'(alu_control), 64'd7);
    chk("srai_imm", 64'(imm), 64'd3);
    chk("srai_srcb", 64'(src_b_sel), 64'd1);
    chk("srai_rs1", 64'(rs1), 64'd2);

    // addi x1,x0,-1
    instr = 32'hFFF00093;
    tick;
    chk("addi_alu", 64'(alu_control), 64'd8);
    chk("addi_imm", 64'(imm), 64'hFFFFFFFF);
    chk("addi_srca", 64'(src_a_sel), 64'd0);

    // lui x1,0x12345
    instr = 32'h123450B7;
    tick;
    chk("lui_imm", 64'(imm), 64'h12345000);
    chk("lui_srca", 64'(src_a_sel), 64'd2);
    chk("lui_alu", 64'(alu_control), 64'd8);
    chk("lui_rd", 64'(rd), 64'd1);

    // auipc x1,0xA at pc 0x100
    instr = 32'h0000A097; pc = 32'h100;
    tick;
    chk("auipc_srca", 64'(src_a_sel), 64'd1);
    chk("auipc_imm", 64'(imm), 64'h0000A000);
    chk("auipc_pc", 64'(pc_out), 64'h100);

    // ecall: unsupported opcode
    instr = 32'h00000073;
    tick;
    chk("ecall_illegal", 64'(illegal), 64'd1);
    chk("ecall_alu", 64'(alu_control), 64'd0);
    chk("ecall_regw", 64'(reg_write), 64'd0);

    // xor encoding with funct7 = 0x01
    instr = 32'h0220C1B3;
    tick;
    chk("f7_illegal", 64'(illegal), 64'd1);
    chk("f7_alu", 64'(alu_control), 64'd0);
    chk("f7_regw", 64'(reg_write), 64'd0);
    chk("f7_slt", 64'(slt_mode), 64'd0);
    chk("f7_rs1", 64'(rs1), 64'd1);
    chk("f7_rs2", 64'(rs2), 64'd2);
    chk("f7_rd", 64'(rd), 64'd3);

    // sltu x3,x1,x2
    instr = 32'h0020B1B3;
    tick;
    chk("sltu_alu", 64'(alu_control), 64'd12);
    chk("sltu_mode", 64'(slt_mode), 64'd2);
    chk("sltu_illegal", 64'(illegal), 64'd0);
`ifdef ALU_OP_DECODER_COUNT_EN
    chk("count_skip_illegal", 64'(decode_count), 64'd6);
`endif
    in_valid = 1'b0;
    tick;
    chk("drain_empty", 64'(out_valid), 64'd0);
`ifdef ALU_OP_DECODER_COUNT_EN
    chk("count_after_drain", 64'(decode_count), 64'd7);
`endif

    // Downstream stall: three offered, two accepted
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3; pc = 32'h200;
    tick;
    chk("stall1_in_ready", 64'(in_ready), 64'd1);
    instr = 32'h407302B3; pc = 32'h204;
    tick;
    chk("stall2_in_ready", 64'(in_ready), 64'd0);
    chk("stall2_alu", 64'(alu_control), 64'd8);
    instr = 32'h0020C1B3; pc = 32'h208;
    tick;
    chk("stall3_in_ready", 64'(in_ready), 64'd0);
    chk("stall3_alu", 64'(alu_control), 64'd8);
    chk("stall3_pc", 64'(pc_out), 64'h200);
    tick;
    chk("stall4_pc", 64'(pc_out), 64'h200);
    chk("stall4_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick;
    chk("rel1_alu", 64'(alu_control), 64'd12);
    chk("rel1_pc", 64'(pc_out), 64'h204);
    chk("rel1_in_ready", 64'(in_ready), 64'd1);
    tick;
    chk("rel2_alu", 64'(alu_control), 64'd3);
    chk("rel2_pc", 64'(pc_out), 64'h208);
    in_valid = 1'b0;
    tick;
    chk("rel3_empty", 64'(out_valid), 64'd0);

    // Reset while both entries are full
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3; pc = 32'h300;
    tick;
    instr = 32'h40315093; pc = 32'h304;
    tick;
    chk("two_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_alu", 64'(alu_control), 64'd0);
    chk("midrst_pc", 64'(pc_out), 64'h0);
    chk("midrst_rd", 64'(rd), 64'd0);
`ifdef ALU_OP_DECODER_COUNT_EN
    chk("midrst_count", 64'(decode_count), 64'd0);
`endif
    tick;
    rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h123450B7; pc = 32'h400;
    tick;
    chk("post_valid", 64'(out_valid), 64'd1);
    chk("post_imm", 64'(imm), 64'h12345000);
    chk("post_pc", 64'(pc_out), 64'h400);
    in_valid = 1'b0;
    tick;
    chk("post_no_stale", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_op_decoder.md
Name: alu_op_decoder

Overview:
- Registered decode stage that sits upstream of the ALU and produces the `alu_control_t` code and operand steering the ALU consumes.
- Accepts 32-bit RV32I instruction words over a valid/ready handshake.
- Decodes OP, OP-IMM, LUI and AUIPC into ALU control, immediate, register indices and select signals.
- Emits the decoded result through a 2-entry skid buffer, so upstream and downstream stalls never drop or duplicate an instruction.

Parameters:
- N, 32, datapath width of the `pc`, `imm` and `pc_out` fields (instruction word is fixed at 32 bits).

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  block can accept an instruction this cycle.
- instr  input  32  instruction word.
- pc  input  N  address of `instr`.
- out_valid  output  1  decoded fields are valid.
- out_ready  input  1  downstream accepts the decoded fields.
- alu_control  output  4  `alu_control_t` code: AND=1, OR=2, XOR=3, SLL=5, SRL=6, SRA=7, ADD=8, SUB=12, none=0.
- slt_mode  output  2  0 = none, 1 = signed SLT, 2 = unsigned SLTU (ALU runs SUB; compare is resolved downstream).
- src_a_sel  output  2  0 = rs1, 1 = pc, 2 = zero.
- src_b_sel  output  1  0 = rs2, 1 = imm.
- imm  output  N  sign-extended immediate.
- rs1, rs2, rd  output  5 each  register indices.
- pc_out  output  N  pc of the decoded instruction.
- reg_write  output  1  instruction writes rd.
- illegal  output  1  instruction not decodable by this block.
- decode_count  output  16  only present when the optional feature is enabled.

Behaviour:
- Reset, asynchronous on `rst_n` low:
  - State = EMPTY, `out_valid` = 0, `in_ready` = 1.
  - Every registered output field = 0.
  - Reset mid-transfer discards both buffer entries.
- Handshake:
  - A transfer occurs when `valid` and `ready` are both high on a rising edge.
  - `in_ready` is a function of registered state only, with no combinational path from `out_ready`.
  - Latency is 1 cycle: an instruction accepted at edge k is presented at edge k+1 if the output register is free.
- States:
  - EMPTY: output register empty, `in_ready` = 1. On accept, go to ONE.
  - ONE: output register full, skid empty, `in_ready` = 1.
    - Accept and no drain: go to TWO, new entry to skid.
    - Accept and drain: stay ONE, new entry to output.
    - Drain only: go to EMPTY.
  - TWO: both entries full, `in_ready` = 0. On drain, skid moves to output and state goes to ONE.
- Ordering is strictly FIFO, and output fields stay stable while `out_valid` is high and `out_ready` is low.
- Decode, OP (0110011), selects rs1/rs2, `reg_write` = 1. By funct3:
  - 000: ADD when funct7 = 0x00, SUB when funct7 = 0x20.
  - 001: SLL.
  - 010: SUB with `slt_mode` = 1.
  - 011: SUB with `slt_mode` = 2.
  - 100: XOR.
  - 101: SRL when funct7 = 0x00, SRA when funct7 = 0x20.
  - 110: OR.
  - 111: AND.
  - Any other funct7 is illegal.
- Decode, OP-IMM (0010011): same funct3 map with `src_b_sel` = imm and no SUB variant.
  - funct3 000 is always ADD.
  - SLLI requires funct7 = 0x00.
  - SRLI/SRAI require funct7 = 0x00 / 0x20; `imm` = zero-extended shamt.
  - Otherwise `imm` = sign-extended instr[31:20].
- Decode, LUI (0110111): ADD, `src_a_sel` = zero, `src_b_sel` = imm, `imm` = {instr[31:12], 12'b0}.
- Decode, AUIPC (0010111): ADD, `src_a_sel` = pc, `src_b_sel` = imm, same `imm` as LUI.
- Illegal instruction:
  - Any other opcode or illegal funct7 gives `illegal` = 1, `alu_control` = 0, `reg_write` = 0, `slt_mode` = 0.
  - The entry is still emitted and consumes a slot.
- `rs1`/`rs2`/`rd` are always taken from instr[19:15], instr[24:20] and instr[11:7], including for illegal instructions.
- Simultaneous accept and drain in ONE: throughput is 1 per cycle with no bubble.

Optional Feature:
- Macro: ALU_OP_DECODER_COUNT_EN.
- Defined:
  - Port `decode_count` exists, a 16-bit counter reset to 0.
  - It increments on every output transfer where `illegal` = 0.
  - It wraps 0xFFFF to 0x0000 silently.
- Undefined: neither the port nor the counter exists, and all other behaviour is identical.

Test Plan:
- `instr` = 0x002081B3 (add x3,x1,x2), `out_ready` = 1 -> one cycle later `alu_control` = 8, rs1 = 1, rs2 = 2, rd = 3, `src_b_sel` = 0, `reg_write` = 1.
- 0x407302B3 (sub) then 0x40315093 (srai x1,x2,3) back-to-back -> `alu_control` 12, then 7 with `imm` = 3, on consecutive cycles.
- 0xFFF00093 (addi x1,x0,-1) -> `imm` = 0xFFFFFFFF, ADD; 0x123450B7 (lui) -> `imm` = 0x12345000, `src_a_sel` = 2; 0x0000A097 (auipc x1,0xA) with `pc` = 0x100 -> `src_a_sel` = 1, `imm` = 0x0000A000, `pc_out` = 0x100.
- `out_ready` = 0, offer 3 instructions -> only 2 accepted, `in_ready` = 0 in TWO, outputs stable; raise `out_ready` -> all 3 delivered in order, no duplicates.
- 0x00000073 (ecall) and 0x0020C1B3 with funct7 = 0x01 -> `illegal` = 1, `alu_control` = 0, `reg_write` = 0; `decode_count` does not increment (with ALU_OP_DECODER_COUNT_EN).
- Assert `rst_n` low while in TWO -> immediately `out_valid` = 0, `in_ready` = 1, outputs 0; after release the next instruction decodes normally.
